// File: rtl/bht_predictor.sv
// Tagged branch history table with saturating counters; optional gshare indexing
// with a speculative global history register repaired on mispredict.
module bht_predictor #(
   parameter int IDX_W = 8,
   parameter int TAG_W = 8,
   parameter int CNT_W = 2,
   parameter int GHR_W = 8,
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   output logic             p_ready,
   input  logic             p_valid,
   input  logic [31:0]      p_pc,
   output logic             p_rsp_valid,
   output logic             p_hit,
   output logic             p_taken,
   output logic [GHR_W-1:0] p_ghr,
   input  logic             u_valid,
   input  logic [31:0]      u_pc,
   input  logic             u_taken,
   input  logic             u_mispredict,
   input  logic [GHR_W-1:0] u_ghr
);
   localparam int DEPTH = 2**IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(2**(CNT_W-1)-1);
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(2**(CNT_W-1));

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
      logic [CNT_W-1:0] cnt;
   } entry_t;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t           state;
   logic [IDX_W-1:0] sweep;
   logic [GHR_W-1:0] ghr, ghr_nx;
   entry_t           tbl [DEPTH];

   logic [IDX_W-1:0] p_idx, u_idx;
   logic [TAG_W-1:0] p_tag, u_tag;
   entry_t           p_ent, u_ent, u_nx;
   logic             p_acc, u_acc, p_hit_nx, p_taken_nx, u_hit;
   logic             unused;

   assign unused = ^{p_pc[31:IDX_W+TAG_W+2], p_pc[1:0], u_pc[31:IDX_W+TAG_W+2], u_pc[1:0]};

   assign p_idx = p_pc[IDX_W+1:2] ^ ((MODE == 1) ? IDX_W'(ghr)   : '0);
   assign u_idx = u_pc[IDX_W+1:2] ^ ((MODE == 1) ? IDX_W'(u_ghr) : '0);
   assign p_tag = p_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign u_tag = u_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign p_ent = tbl[p_idx];
   assign u_ent = tbl[u_idx];

   assign p_acc      = (state == RUN) && p_valid && !flush;
   assign u_acc      = (state == RUN) && u_valid && !flush;
   assign p_hit_nx   = p_ent.vld && (p_ent.tag == p_tag);
   assign p_taken_nx = p_hit_nx && p_ent.cnt[CNT_W-1];
   assign u_hit      = u_ent.vld && (u_ent.tag == u_tag);

   always_comb begin
      u_nx = u_ent;
      if (u_hit) begin
         if (u_taken && (u_ent.cnt != CNT_MAX))
            u_nx.cnt = u_ent.cnt + CNT_W'(1);
         else if (!u_taken && (u_ent.cnt != '0))
            u_nx.cnt = u_ent.cnt - CNT_W'(1);
      end else begin
         u_nx.vld = 1'b1;
         u_nx.tag = u_tag;
         u_nx.cnt = u_taken ? CNT_WT : CNT_WNT;
      end
   end

   // Repair takes priority over the speculative shift from a same-cycle predict.
   always_comb begin
      ghr_nx = ghr;
      if (MODE == 1) begin
         if (u_acc && u_mispredict)
            ghr_nx = {u_ghr[GHR_W-2:0], u_taken};
         else if (p_acc)
            ghr_nx = {ghr[GHR_W-2:0], p_taken_nx};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= CLEAR;
         sweep       <= '0;
         ghr         <= '0;
         p_ready     <= 1'b0;
         p_rsp_valid <= 1'b0;
         p_hit       <= 1'b0;
         p_taken     <= 1'b0;
         p_ghr       <= '0;
      end else if (flush) begin
         state       <= CLEAR;
         sweep       <= '0;
         ghr         <= '0;
         p_ready     <= 1'b0;
         p_rsp_valid <= 1'b0;
      end else begin
         p_rsp_valid <= p_acc;
         if (p_acc) begin
            p_hit   <= p_hit_nx;
            p_taken <= p_taken_nx;
            p_ghr   <= ghr;
         end
         case (state)
            CLEAR: begin
               sweep <= sweep + IDX_W'(1);
               if (sweep == IDX_W'(DEPTH-1)) begin
                  state   <= RUN;
                  p_ready <= 1'b1;
               end
            end
            RUN: ghr <= ghr_nx;
            default: state <= CLEAR;
         endcase
      end
   end

   // Table has no reset; the sweep initialises it. Reads above see the pre-write value.
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         tbl[sweep] <= '{vld: 1'b0, tag: '0, cnt: CNT_WNT};
      else if (u_acc)
         tbl[u_idx] <= u_nx;
   end
endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench: one bimodal and one gshare instance driven from a single sequence.
module tb_bht_predictor;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
   always #5 clk = ~clk;

   logic        b_ready, b_pv, b_rv, b_hit, b_tk, b_uv, b_ut, b_um;
   logic [31:0] b_ppc, b_upc;
   logic [7:0]  b_pghr, b_ughr;
   logic        g_ready, g_pv, g_rv, g_hit, g_tk, g_uv, g_ut, g_um;
   logic [31:0] g_ppc, g_upc;
   logic [7:0]  g_pghr, g_ughr;

   int n_assert = 0, n_fail = 0;

   bht_predictor #(.IDX_W(8), .TAG_W(8), .CNT_W(2), .GHR_W(8), .MODE(0)) u_bim (
      .clk(clk), .rst(rst), .flush(flush), .p_ready(b_ready),
      .p_valid(b_pv), .p_pc(b_ppc), .p_rsp_valid(b_rv), .p_hit(b_hit),
      .p_taken(b_tk), .p_ghr(b_pghr), .u_valid(b_uv), .u_pc(b_upc),
      .u_taken(b_ut), .u_mispredict(b_um), .u_ghr(b_ughr));

   bht_predictor #(.IDX_W(8), .TAG_W(8), .CNT_W(2), .GHR_W(8), .MODE(1)) u_gsh (
      .clk(clk), .rst(rst), .flush(flush), .p_ready(g_ready),
      .p_valid(g_pv), .p_pc(g_ppc), .p_rsp_valid(g_rv), .p_hit(g_hit),
      .p_taken(g_tk), .p_ghr(g_pghr), .u_valid(g_uv), .u_pc(g_upc),
      .u_taken(g_ut), .u_mispredict(g_um), .u_ghr(g_ughr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Drives the bimodal instance; pv/uv select which requests are issued this cycle.
   task automatic b_cyc(input logic pv, input logic [31:0] ppc,
                        input logic uv, input logic [31:0] upc, input logic ut);
      b_pv = pv; b_ppc = ppc; b_uv = uv; b_upc = upc; b_ut = ut;
      tick();
      b_pv = 1'b0; b_uv = 1'b0;
   endtask

   task automatic g_cyc(input logic pv, input logic [31:0] ppc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic um,
                        input logic [7:0] ughr);
      g_pv = pv; g_ppc = ppc; g_uv = uv; g_upc = upc; g_ut = ut; g_um = um; g_ughr = ughr;
      tick();
      g_pv = 1'b0; g_uv = 1'b0; g_um = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int start, input int exp);
      int n = start;
      while (!b_ready && n < 1000) begin
         tick();
         n++;
      end
      chk(tag, n, exp);
   endtask

   initial begin
      b_pv = 0; b_ppc = 0; b_uv = 0; b_upc = 0; b_ut = 0; b_um = 0; b_ughr = 0;
      g_pv = 0; g_ppc = 0; g_uv = 0; g_upc = 0; g_ut = 0; g_um = 0; g_ughr = 0;

      // 1. reset state and clear sweep length
      #12;
      chk("rst_ready", b_ready, 0);
      chk("rst_rv",    b_rv,    0);
      chk("rst_hit",   b_hit,   0);
      chk("rst_taken", b_tk,    0);
      chk("rst_ghr",   g_pghr,  0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_ready("sweep_len", 0, 256);
      chk("g_ready", g_ready, 1);
      b_cyc(1, 32'h100, 0, 0, 0);
      chk("cold_rv", b_rv, 1);
      chk("cold_hit", b_hit, 0);
      chk("cold_taken", b_tk, 0);
      tick();
      chk("rv_one_cycle", b_rv, 0);

      // 2. bimodal counter and saturation
      b_cyc(0, 0, 1, 32'h100, 1);
      b_cyc(1, 32'h100, 0, 0, 0);
      chk("c10_hit", b_hit, 1);
      chk("c10_taken", b_tk, 1);
      chk("bim_ghr0", b_pghr, 0);
      b_cyc(0, 0, 1, 32'h100, 1);
      b_cyc(0, 0, 1, 32'h100, 1);
      b_cyc(1, 32'h100, 0, 0, 0);
      chk("c11_taken", b_tk, 1);
      tick();
      chk("hold_rv", b_rv, 0);
      chk("hold_hit", b_hit, 1);
      chk("hold_taken", b_tk, 1);
      b_cyc(0, 0, 1, 32'h100, 0);
      b_cyc(0, 0, 1, 32'h100, 0);
      b_cyc(1, 32'h100, 0, 0, 0);
      chk("c01_taken", b_tk, 0);
      for (int i = 0; i < 4; i++) b_cyc(0, 0, 1, 32'h100, 0);
      b_cyc(0, 0, 1, 32'h100, 1);
      b_cyc(1, 32'h100, 0, 0, 0);
      chk("sat0_then01", b_tk, 0);
      b_cyc(0, 0, 1, 32'h100, 1);
      b_cyc(1, 32'h100, 0, 0, 0);
      chk("sat0_then10", b_tk, 1);

      // 3. alias: same index, different tag
      b_cyc(1, 32'h500, 0, 0, 0);
      chk("alias_miss", b_hit, 0);
      b_cyc(0, 0, 1, 32'h500, 0);
      b_cyc(1, 32'h500, 0, 0, 0);
      chk("alias_hit", b_hit, 1);
      chk("alias_taken", b_tk, 0);
      b_cyc(1, 32'h100, 0, 0, 0);
      chk("alias_evict", b_hit, 0);

      // 4. gshare: speculative history and repair
      g_cyc(0, 0, 1, 32'h100, 1, 0, 8'h00);
      g_cyc(0, 0, 1, 32'h100, 1, 0, 8'h01);
      g_cyc(0, 0, 1, 32'h100, 1, 0, 8'h03);
      g_cyc(1, 32'h100, 0, 0, 0, 0, 0);
      chk("gs0_ghr", g_pghr, 8'h00);
      chk("gs0_taken", g_tk, 1);
      g_cyc(1, 32'h100, 0, 0, 0, 0, 0);
      chk("gs1_ghr", g_pghr, 8'h01);
      chk("gs1_hit", g_hit, 1);
      g_cyc(1, 32'h100, 0, 0, 0, 0, 0);
      chk("gs2_ghr", g_pghr, 8'h03);
      chk("gs2_taken", g_tk, 1);
      g_cyc(1, 32'h100, 1, 32'h100, 1, 1, 8'h5A);
      chk("gs3_ghr", g_pghr, 8'h07);
      g_cyc(1, 32'h100, 0, 0, 0, 0, 0);
      chk("gs_repair", g_pghr, 8'hB5);

      // 5. same-cycle predict and update: read-before-write
      b_cyc(0, 0, 1, 32'h200, 0);
      b_cyc(1, 32'h200, 1, 32'h200, 1);
      chk("haz_hit", b_hit, 1);
      chk("haz_old", b_tk, 0);
      b_cyc(1, 32'h200, 0, 0, 0);
      chk("haz_new", b_tk, 1);

      // 6. flush, then flush again mid-sweep at entry 100
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush_ready", b_ready, 0);
      for (int i = 0; i < 100; i++) tick();
      chk("mid_ready", b_ready, 0);
      flush = 1'b1; tick(); flush = 1'b0;
      b_cyc(1, 32'h200, 0, 0, 0);
      chk("clear_no_rsp", b_rv, 0);
      wait_ready("resweep_len", 1, 256);
      b_cyc(1, 32'h200, 0, 0, 0);
      chk("flush_rv", b_rv, 1);
      chk("flush_miss", b_hit, 0);
      g_cyc(1, 32'h100, 0, 0, 0, 0, 0);
      chk("flush_ghr", g_pghr, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
